// File: rtl/register_universal_r_sync.sv
// register_universal_r_sync: WIDTH-bit universal register (hold/load/shift/rotate/increment/clear) with sync active-low reset
// Ports: clk, reset_n (sync, active-low), en (clock enable), mode[2:0], d[WIDTH-1:0],
//        sin_r (serial in to bit 0), sin_l (serial in to bit WIDTH-1), q[WIDTH-1:0],
//        sout_l = q[WIDTH-1], sout_r = q[0], zero = (q == 0), wrap (increment wrap flag).
// Optional macro REGISTER_UNIVERSAL_WRAP_EN: wrap is a registered one-cycle pulse after an
// increment from all-ones; without it wrap is tied to 0.
module register_universal_r_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             wrap
);
    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] INC  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;
    logic [WIDTH-1:0] q_next;
    always_comb begin
        q_next = q;
        case (mode)
            HOLD: q_next = q;
            LOAD: q_next = d;
            SHL:  q_next = {q[WIDTH-2:0], sin_r};
            SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:  q_next = {q[0], q[WIDTH-1:1]};
            INC:  q_next = q + 1'b1;
            CLR:  q_next = '0;
            default: q_next = q;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= '0;
        else if (en)
            q <= q_next;
    end
    // Serial outputs expose pre-edge bits so cascaded stages shift coherently.
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);
`ifdef REGISTER_UNIVERSAL_WRAP_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            wrap <= 1'b0;
        else
            wrap <= en && (mode == INC) && (&q);
    end
`else
    assign wrap = 1'b0;
`endif
endmodule

// File: tb/tb_register_universal_r_sync.sv
// tb_register_universal_r_sync: randomized self-checking bench against an arithmetic reference model
module tb_register_universal_r_sync;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] q;
    logic       sout_l, sout_r, zero, wrap;
    int checks = 0;
    int errors = 0;
    int m = 0;
    bit mw = 1'b0;
    bit ew;

    register_universal_r_sync #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .zero(zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int model(int cur, bit rn, bit e, int md, int dv, bit sr, bit sl);
        if (!rn) return 0;
        if (!e) return cur;
        case (md)
            0: return cur;
            1: return dv;
            2: return (cur * 2 + sr) % 256;
            3: return cur / 2 + sl * 128;
            4: return (cur * 2) % 256 + cur / 128;
            5: return cur / 2 + (cur % 2) * 128;
            6: return (cur + 1) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic step(bit rn, bit e, int md, int dv, bit sr, bit sl);
        reset_n = rn; en = e; mode = md[2:0]; d = dv[7:0]; sin_r = sr; sin_l = sl;
        @(posedge clk);
        mw = rn && e && md == 6 && m == 255;
        m = model(m, rn, e, md, dv, sr, sl);
`ifdef REGISTER_UNIVERSAL_WRAP_EN
        ew = mw;
`else
        ew = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset;
        step(0, 1, 1, 8'h5A, 1, 1);
        step(0, 1, 6, 8'h5A, 1, 1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
        checks++; if (sout_l !== 1'b0 || sout_r !== 1'b0) begin errors++; $display("FAIL reset_sout got %b%b want 00", sout_l, sout_r); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    endtask

    task automatic test_load;
        step(1, 1, 1, 8'hA5, 0, 0);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q got %h want a5", q); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL load_zero got %b want 0", zero); end
        checks++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin errors++; $display("FAIL load_sout got %b%b want 11", sout_l, sout_r); end
    endtask

    task automatic test_shift;
        step(1, 1, 2, 0, 0, 0);
        checks++; if (q !== 8'h4A) begin errors++; $display("FAIL shl_q got %h want 4a", q); end
        step(1, 1, 3, 0, 0, 1);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL shr_q got %h want a5", q); end
    endtask

    task automatic test_rotate;
        step(1, 1, 1, 8'h81, 0, 0);
        step(1, 1, 4, 0, 0, 0);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rol_q got %h want 03", q); end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 5, $urandom_range(255), $urandom_range(1), $urandom_range(1));
            checks++; if (q !== m[7:0]) begin errors++; $display("FAIL ror_step%0d got %h want %h", i, q, m[7:0]); end
        end
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL ror8_q got %h want 03", q); end
    endtask

    task automatic test_increment;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'hFF; exp_q[1] = 8'h00; exp_q[2] = 8'h01;
        step(1, 1, 1, 8'hFE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 6, $urandom_range(255), 0, 0);
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL inc%0d_q got %h want %h", i, q, exp_q[i]); end
            checks++; if (wrap !== ew) begin errors++; $display("FAIL inc%0d_wrap got %b want %b", i, wrap, ew); end
        end
    endtask

    task automatic test_enable_clear;
        step(1, 1, 1, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 7, $urandom_range(255), 1, 1);
            checks++; if (q !== 8'h3C) begin errors++; $display("FAIL en_low%0d_q got %h want 3c", i, q); end
        end
        step(1, 1, 7, 8'hFF, 1, 1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL clear_q got %h want 00", q); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL clear_zero got %b want 1", zero); end
    endtask

    task automatic test_reset_priority;
        step(1, 1, 1, 8'h77, 0, 0);
        @(negedge clk);
        reset_n = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hFF;
        #2;
        checks++; if (q !== 8'h77) begin errors++; $display("FAIL rstmid_q got %h want 77", q); end
        @(posedge clk);
        m = 0; mw = 1'b0; ew = 1'b0;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rstprio_q got %h want 00", q); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rstprio_wrap got %b want 0", wrap); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(31) != 0, $urandom_range(7) != 0,
                 ($urandom_range(3) == 0) ? 6 : $urandom_range(7),
                 ($urandom_range(3) == 0) ? 8'hFF : $urandom_range(255),
                 $urandom_range(1), $urandom_range(1));
            d = $urandom_range(255); sin_r = ~sin_r; sin_l = ~sin_l;
            checks++; if (q !== m[7:0]) begin errors++; $display("FAIL rand%0d_q got %h want %h", i, q, m[7:0]); end
            checks++; if (zero !== (m == 0)) begin errors++; $display("FAIL rand%0d_zero got %b want %b", i, zero, m == 0); end
            checks++; if (sout_l !== m[7] || sout_r !== m[0]) begin errors++; $display("FAIL rand%0d_sout got %b%b want %b%b", i, sout_l, sout_r, m[7], m[0]); end
            checks++; if (wrap !== ew) begin errors++; $display("FAIL rand%0d_wrap got %b want %b", i, wrap, ew); end
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_shift;
        test_rotate;
        test_increment;
        test_enable_clear;
        test_reset_priority;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_universal_r_sync.md
Name: register_universal_r_sync

Overview:
- Parametrised successor to the team's fixed-width async-reset state register.
- A WIDTH-bit universal register with synchronous active-low reset and clock enable.
- Eight operating modes: hold, parallel load, shift left/right, rotate left/right, increment and clear.
- Serves as the general state, shift-chain and counter element in FSM datapaths, with serial ports for cascading.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- en  input  1  clock enable; when low, the register holds regardless of mode.
- mode  input  3  operation select (encodings under Behaviour).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input shifted into bit 0 on shift left.
- sin_l  input  1  serial input shifted into bit WIDTH-1 on shift right.
- q  output  WIDTH  registered contents.
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- sout_r  output  1  equals q[0] (combinational from q).
- zero  output  1  high when q == 0 (combinational from q).
- wrap  output  1  increment wrap pulse; exists only under the optional feature, otherwise constant 0.

Behaviour:
- Clock and reset:
  - Clock is clk; reset is reset_n, synchronous and active-low.
  - All state changes occur on the rising edge of clk only.
- Reset:
  - reset_n sampled low at a rising edge sets q = 0 and wrap = 0.
  - Reset has priority over en and mode.
  - Asserting reset_n mid-operation discards any in-progress op; there is no asynchronous path.
- Reset values:
  - q = 0, so sout_l = 0, sout_r = 0, zero = 1, wrap = 0.
- Priority at each rising edge: reset, then en == 0 (hold), then mode.
- Mode encodings (new q derived from current q):
  - 000 hold: q unchanged.
  - 001 load: q = d.
  - 010 shift left: q = {q[WIDTH-2:0], sin_r}.
  - 011 shift right: q = {sin_l, q[WIDTH-1:1]}.
  - 100 rotate left: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q = {q[0], q[WIDTH-1:1]}.
  - 110 increment: q = q + 1 modulo 2^WIDTH; all-ones wraps to 0.
  - 111 clear: q = 0.
- Latency:
  - Every op is visible on q one cycle after the sampling edge.
  - Derived outputs follow q in the same cycle.
- Serial cascading:
  - sout_l of stage n drives sin_r of stage n+1.
  - sout_r of stage n+1 drives sin_l of stage n.
  - Shift-out values are the pre-edge q bits, so chained registers shift coherently on a common clk.
- Boundary conditions:
  - en low with any mode, including 111: no change.
  - Changes on d, sin_l or sin_r between edges have no effect.
  - Back-to-back increments from all-ones give 0, then 1.
  - Rotate by WIDTH consecutive cycles returns the original value.
- Control inputs are assumed stable around the edge; there is no X-propagation masking.

Optional Feature:
- Macro: REGISTER_UNIVERSAL_WRAP_EN.
- Defined:
  - wrap is a registered flag, high for exactly one cycle after an edge where en = 1, mode = 110 and q was all-ones.
  - Otherwise wrap = 0 at every edge, including hold, load and reset.
- Undefined:
  - wrap is tied to 0 and no extra flop is inferred.
  - All other behaviour is identical.

Test Plan (WIDTH = 8):
- Reset and load:
  - reset_n = 0 for 2 edges -> q = 0x00, zero = 1.
  - Then en = 1, mode = 001, d = 0xA5 -> next cycle q = 0xA5, zero = 0, sout_l = 1, sout_r = 1.
- Shift:
  - From q = 0xA5, mode = 010, sin_r = 0 -> q = 0x4A.
  - Then mode = 011, sin_l = 1 -> q = 0xA5.
- Rotate:
  - From q = 0x81, mode = 100 -> q = 0x03.
  - Then 8 edges of mode = 101 starting at 0x03 -> q = 0x03.
- Increment and wrap:
  - Load 0xFE, mode = 110 for 3 edges -> q = 0xFF, 0x00, 0x01.
  - With REGISTER_UNIVERSAL_WRAP_EN, wrap = 1 only in the cycle where q = 0x00.
  - Without the macro, wrap = 0 throughout.
- Enable and clear:
  - q = 0x3C, en = 0, mode = 111 for 3 edges -> q stays 0x3C.
  - en = 1 -> q = 0x00, zero = 1.
- Synchronous reset priority:
  - q = 0x77, drop reset_n between edges -> q holds 0x77 until the next rising edge.
  - At that edge, with en = 1, mode = 001, d = 0xFF -> q = 0x00, not 0xFF.
